// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Instruction fetch front end. Holds a fetch PC that addresses a
//   combinational-read instruction memory and buffers fetched {pc, inst}
//   pairs in a 2-entry FIFO for decode. It supports redirects (flush and
//   refetch) and a halt request that drains the FIFO before stopping.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   imem_ra        instruction memory read address (current fetch PC)
//   imem_rd        instruction word for imem_ra, same cycle
//   redirect_valid flush FIFO and restart fetching at redirect_pc
//   redirect_pc    redirect target byte address (low two bits ignored)
//   halt_req       stop fetching, drain FIFO, then halt
//   out_valid      FIFO head available to decode
//   out_ready      decode accepts the head entry
//   out_inst       head instruction (0 when empty)
//   out_pc         head PC (0 when empty)
//   halted         fetch stopped and FIFO empty
//   fifo_count     FIFO occupancy, 0..2
//
// State  | meaning
// RUN    | fetching; push whenever a slot is free or one is popped
// DRAIN  | no more fetches; decode empties the FIFO
// HALTED | stopped; PC frozen until a redirect
// ---------------------------------------------------------------------------
module fetch_controller #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  input  logic                   halt_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_W-1:0]       out_inst,
  output logic [INS_ADDRESS-1:0] out_pc,
  output logic                   halted,
  output logic [1:0]             fifo_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  // Entry 0 is always the head; entry 1 is the tail when two are held.
  logic [INS_ADDRESS-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INS_W-1:0]       inst0_q, inst0_d, inst1_q, inst1_d;
  logic [1:0]             count_q, count_d;
  logic                   pop, push;

  assign imem_ra    = pc_q;
  assign fifo_count = count_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_pc     = out_valid ? pc0_q : '0;
  assign out_inst   = out_valid ? inst0_q : '0;
  assign halted     = (state_q == HALTED);

  assign pop  = out_valid & out_ready;
  assign push = (state_q == RUN) & ~redirect_valid & ((count_q < 2'd2) | pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    count_d = count_q;

    if (redirect_valid) begin
      // A same-cycle pop still completes for decode; the entry is just dropped.
      count_d = 2'd0;
      pc_d    = redirect_pc & ~INS_ADDRESS'(3);
      state_d = RUN;
    end else begin
      if (pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (push) begin
        pc_d = pc_q + INS_ADDRESS'(4);
        // New entry lands in the first slot that is free after the pop.
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          pc0_d   = pc_q;
          inst0_d = imem_rd;
        end else begin
          pc1_d   = pc_q;
          inst1_d = imem_rd;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      case (state_q)
        RUN:     if (halt_req) state_d = DRAIN;
        DRAIN:   if (count_d == 2'd0) state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= INS_ADDRESS'(RESET_PC);
      pc0_q   <= '0;
      pc1_q   <= '0;
      inst0_q <= '0;
      inst1_q <= '0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//   Self-checking bench for fetch_controller: a table of directed vectors,
//   hand-written drain/halt/reset sequences, then randomized traffic checked
//   against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int RESET_PC = 0;
  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  imem_ra;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [8:0]  out_pc;
  logic        halted;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_pc;
  int m_q[$];
  int m_mode;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [8:0] a);
    return 32'h1357_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  assign imem_rd = mem(imem_ra);

  fetch_controller #(
    .INS_ADDRESS(9),
    .INS_W(32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_ra(imem_ra),
    .imem_rd(imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt_req(halt_req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .halted(halted),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic rv, input logic [8:0] rp,
                            input logic h, input logic rd);
    bit do_pop, do_push;
    if (r) begin
      m_pc = RESET_PC;
      m_q.delete();
      m_mode = M_RUN;
    end else begin
      do_pop = (m_q.size() != 0) && rd;
      if (rv) begin
        m_q.delete();
        m_pc = int'(rp) & 32'h1FC;
        m_mode = M_RUN;
      end else begin
        do_push = (m_mode == M_RUN) && ((m_q.size() < 2) || do_pop);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
          m_q.push_back(m_pc);
          m_pc = (m_pc + 4) % 512;
        end
        if (m_mode == M_RUN && h) m_mode = M_DRAIN;
        else if (m_mode == M_DRAIN && m_q.size() == 0) m_mode = M_HALT;
      end
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [8:0] rp,
                      input logic h, input logic rd);
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt_req       = h;
    out_ready      = rd;
    @(posedge clk);
    model_edge(r, rv, rp, h, rd);
    #1;
  endtask

  task automatic check_model(input int cyc);
    int n;
    int hd;
    n  = m_q.size();
    hd = (n != 0) ? m_q[0] : 0;
    chk($sformatf("rnd%0d_valid", cyc), 32'(out_valid), 32'(n != 0));
    chk($sformatf("rnd%0d_count", cyc), 32'(fifo_count), 32'(n));
    chk($sformatf("rnd%0d_halted", cyc), 32'(halted), 32'(m_mode == M_HALT));
    chk($sformatf("rnd%0d_ra", cyc), 32'(imem_ra), 32'(m_pc));
    chk($sformatf("rnd%0d_pc", cyc), 32'(out_pc), 32'(hd));
    chk($sformatf("rnd%0d_inst", cyc), out_inst, (n != 0) ? mem(9'(hd)) : 32'h0);
  endtask

  typedef struct packed {
    logic       rst;
    logic       rv;
    logic [8:0] rp;
    logic       h;
    logic       rd;
    logic       ev;
    logic [8:0] epc;
    logic [1:0] ecnt;
    logic       eh;
    logic [8:0] era;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  function automatic vec_t mk(input logic rst, input logic rv, input logic [8:0] rp,
                              input logic h, input logic rd, input logic ev,
                              input logic [8:0] epc, input logic [1:0] ecnt,
                              input logic eh, input logic [8:0] era);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rp = rp; v.h = h; v.rd = rd;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eh = eh; v.era = era;
    return v;
  endfunction

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    m_pc = RESET_PC; m_mode = M_RUN;

    //             rst rv  rp      h  rd   ev  epc     cnt eh  ra
    vt[0]  = mk(1, 0, 9'h000, 0, 1,  0, 9'h000, 0, 0, 9'h000);
    vt[1]  = mk(0, 0, 9'h000, 0, 1,  1, 9'h000, 1, 0, 9'h004);
    vt[2]  = mk(0, 0, 9'h000, 0, 1,  1, 9'h004, 1, 0, 9'h008);
    vt[3]  = mk(0, 0, 9'h000, 0, 1,  1, 9'h008, 1, 0, 9'h00C);
    vt[4]  = mk(1, 0, 9'h000, 0, 0,  0, 9'h000, 0, 0, 9'h000);
    vt[5]  = mk(0, 0, 9'h000, 0, 0,  1, 9'h000, 1, 0, 9'h004);
    vt[6]  = mk(0, 0, 9'h000, 0, 0,  1, 9'h000, 2, 0, 9'h008);
    vt[7]  = mk(0, 0, 9'h000, 0, 0,  1, 9'h000, 2, 0, 9'h008);
    vt[8]  = mk(0, 0, 9'h000, 0, 0,  1, 9'h000, 2, 0, 9'h008);
    vt[9]  = mk(0, 0, 9'h000, 0, 0,  1, 9'h000, 2, 0, 9'h008);
    vt[10] = mk(0, 0, 9'h000, 0, 1,  1, 9'h004, 2, 0, 9'h00C);
    vt[11] = mk(0, 0, 9'h000, 0, 1,  1, 9'h008, 2, 0, 9'h010);
    vt[12] = mk(0, 1, 9'h056, 0, 0,  0, 9'h000, 0, 0, 9'h054);
    vt[13] = mk(0, 0, 9'h000, 0, 0,  1, 9'h054, 1, 0, 9'h058);
    vt[14] = mk(0, 1, 9'h1FC, 0, 1,  0, 9'h000, 0, 0, 9'h1FC);
    vt[15] = mk(0, 0, 9'h000, 0, 1,  1, 9'h1FC, 1, 0, 9'h000);
    vt[16] = mk(0, 0, 9'h000, 0, 1,  1, 9'h000, 1, 0, 9'h004);

    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].rv, vt[i].rp, vt[i].h, vt[i].rd);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vt[i].epc));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vt[i].ecnt));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].eh));
      chk($sformatf("vec%0d_ra", i), 32'(imem_ra), 32'(vt[i].era));
      chk($sformatf("vec%0d_inst", i), out_inst, vt[i].ev ? mem(vt[i].epc) : 32'h0);
    end

    // Halt pulse at count 2 with decode ready: two more outputs, then halted.
    step(1, 0, 9'h000, 0, 0);
    step(0, 0, 9'h000, 0, 0);
    step(0, 0, 9'h000, 0, 0);
    chk("halt_pre_count", 32'(fifo_count), 32'd2);
    step(0, 0, 9'h000, 1, 1);
    chk("halt_e1_pc", 32'(out_pc), 32'h004);
    chk("halt_e1_count", 32'(fifo_count), 32'd2);
    chk("halt_e1_halted", 32'(halted), 32'd0);
    chk("halt_e1_ra", 32'(imem_ra), 32'h00C);
    step(0, 0, 9'h000, 0, 1);
    chk("halt_e2_pc", 32'(out_pc), 32'h008);
    chk("halt_e2_count", 32'(fifo_count), 32'd1);
    chk("halt_e2_ra", 32'(imem_ra), 32'h00C);
    step(0, 0, 9'h000, 0, 1);
    chk("halt_e3_valid", 32'(out_valid), 32'd0);
    chk("halt_e3_halted", 32'(halted), 32'd1);
    chk("halt_e3_ra", 32'(imem_ra), 32'h00C);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 9'h000, 1, 1);
      chk($sformatf("halt_hold%0d_halted", k), 32'(halted), 32'd1);
      chk($sformatf("halt_hold%0d_ra", k), 32'(imem_ra), 32'h00C);
      chk($sformatf("halt_hold%0d_count", k), 32'(fifo_count), 32'd0);
    end
    step(0, 1, 9'h010, 0, 1);
    chk("halt_redir_halted", 32'(halted), 32'd0);
    chk("halt_redir_ra", 32'(imem_ra), 32'h010);
    chk("halt_redir_count", 32'(fifo_count), 32'd0);
    step(0, 0, 9'h000, 0, 1);
    chk("halt_redir_valid", 32'(out_valid), 32'd1);
    chk("halt_redir_pc", 32'(out_pc), 32'h010);

    // Reset in DRAIN at count 2 overrides a simultaneous redirect.
    step(1, 0, 9'h000, 0, 0);
    step(0, 0, 9'h000, 0, 0);
    step(0, 0, 9'h000, 0, 0);
    step(0, 0, 9'h000, 1, 0);
    chk("drain_count", 32'(fifo_count), 32'd2);
    chk("drain_ra", 32'(imem_ra), 32'h008);
    step(1, 1, 9'h100, 0, 1);
    chk("rst_drain_valid", 32'(out_valid), 32'd0);
    chk("rst_drain_count", 32'(fifo_count), 32'd0);
    chk("rst_drain_halted", 32'(halted), 32'd0);
    chk("rst_drain_ra", 32'(imem_ra), 32'(RESET_PC));
    step(0, 0, 9'h000, 0, 0);
    chk("rst_drain_first_pc", 32'(out_pc), 32'(RESET_PC));
    chk("rst_drain_first_valid", 32'(out_valid), 32'd1);

    // Randomized traffic against the reference model.
    step(1, 0, 9'h000, 0, 0);
    check_model(-1);
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 15) == 0,
           9'($urandom),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
      check_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, meaning the byte-address width of the instruction memory and PC.
REQ-002 SHALL have parameter INS_W, default 32, meaning the instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 SHALL have port: clk  input  1  rising-edge clock; one clock domain.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: imem_ra  output  INS_ADDRESS  read address to instruction memory (combinational-read memory, data in the same cycle).
REQ-007 SHALL have port: imem_rd  input  INS_W  instruction word returned for imem_ra.
REQ-008 SHALL have port: redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port: redirect_pc  input  INS_ADDRESS  redirect target byte address.
REQ-010 SHALL have port: halt_req  input  1  request to stop fetching.
REQ-011 SHALL have port: out_valid  output  1  head entry available to decode.
REQ-012 SHALL have port: out_ready  input  1  decode accepts head entry.
REQ-013 SHALL have port: out_inst  output  INS_W  head instruction.
REQ-014 SHALL have port: out_pc  output  INS_ADDRESS  head PC.
REQ-015 SHALL have port: halted  output  1  fetch stopped and queue empty.
REQ-016 SHALL have port: fifo_count  output  2  queue occupancy, 0..2.

Function
REQ-017 SHALL hold a fetch PC register and a 2-entry FIFO of {pc, inst} pairs.
REQ-018 SHALL drive imem_ra = fetch PC combinationally at all times.
REQ-019 SHALL define pop = out_valid & out_ready.
REQ-020 SHALL define push, in state RUN without redirect, as (fifo_count < 2) | pop, writing {PC, imem_rd}.
REQ-021 SHALL advance the PC on push by PC + 4, modulo 2^INS_ADDRESS, so 0x1FC wraps to 0x000.
REQ-022 SHALL hold the PC, with no push, when not pushing.
REQ-023 SHALL, with simultaneous push and pop at count 2, keep count at 2 with FIFO order preserved.
REQ-024 SHALL drive out_valid = (fifo_count != 0) and drive out_inst/out_pc from the head entry, or 0 when empty.
REQ-025 SHALL keep out_inst/out_pc stable while out_valid & !out_ready.
REQ-026 SHALL, on redirect_valid, give it priority over push and halt_req.
REQ-027 SHALL, on redirect_valid, clear the FIFO at the clock edge; a same-cycle pop is accepted by decode but the entry is discarded internally.
REQ-028 SHALL, on redirect_valid, load PC with redirect_pc with bits [1:0] forced to 0, and enter state RUN from any state.
REQ-029 SHALL have a state machine with states RUN, DRAIN and HALTED.
REQ-030 SHALL, in RUN with halt_req and no redirect, go to DRAIN; pushing stops from that edge.
REQ-031 SHALL, in DRAIN, perform no push, keep popping normally, and go to HALTED on the edge where the FIFO becomes empty; if already empty, go to HALTED on the next edge.
REQ-032 SHALL, in HALTED, drive halted=1, freeze the PC and ignore halt_req; only redirect_valid or reset leaves HALTED.
REQ-033 SHALL have halted depend on state only.
REQ-034 SHALL give a latency of 1 cycle from fetch to out_valid.

Reset
REQ-035 SHALL, while reset=1 at a rising edge, set PC=RESET_PC, FIFO empty, fifo_count=0, state RUN, out_valid=0, out_inst=0, out_pc=0, halted=0.
REQ-036 SHALL let reset override redirect, halt and handshakes, including mid-DRAIN.
REQ-037 SHALL make the first push in the first cycle after reset deasserts.

Verification
REQ-038 SHALL cover: reset release with out_ready=1 held -> out_pc 0x000, 0x004, 0x008 on consecutive cycles, first out_valid 1 cycle after release, fifo_count=1 steady.
REQ-039 SHALL cover: out_ready=0 for 5 cycles -> fifo_count=2, imem_ra held at 0x008, head out_pc=0x000 stable; then out_ready=1 -> 0x000, 0x004, 0x008 with no loss or duplicate.
REQ-040 SHALL cover: redirect_valid with redirect_pc=0x056 at count 2 -> next cycle fifo_count=0 and imem_ra=0x054; cycle after that out_pc=0x054.
REQ-041 SHALL cover: redirect to 0x1FC, out_ready=1 -> out_pc 0x1FC then 0x000.
REQ-042 SHALL cover: halt_req pulse at count 2, out_ready=1 -> exactly two more outputs, then halted=1 and imem_ra frozen; redirect 0x010 -> halted=0 next cycle, then out_pc=0x010.
REQ-043 SHALL cover: reset asserted in DRAIN at count 2 -> next cycle out_valid=0, fifo_count=0, halted=0, imem_ra=RESET_PC.
